mesm6_bus_arbiter: RTL

MESM6_BUS_ARBITER -- requirements
Module: mesm6_bus_arbiter

---
 rtl/mesm6_bus_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mesm6_bus_arbiter.sv
// Two-master memory arbiter for the MESM-6 core: round-robin between the
// instruction fetch port and the data port, with a response watchdog.
module mesm6_bus_arbiter #(
    parameter int TMO_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ibus_fetch,
    input  logic [14:0] ibus_addr,
    output logic [47:0] ibus_input,
    output logic        ibus_done,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [14:0] dbus_addr,
    input  logic [47:0] dbus_output,
    output logic [47:0] dbus_input,
    output logic        dbus_done,
    output logic        mem_read,
    output logic        mem_write,
    output logic [14:0] mem_addr,
    output logic [47:0] mem_wdata,
    input  logic [47:0] mem_rdata,
    input  logic        mem_done,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, DBUS, IBUS, RESP} state_t;

    localparam logic [TMO_BITS-1:0] TMO_ONE = TMO_BITS'(1);
    localparam logic [TMO_BITS-1:0] TMO_MAX = '1;

    state_t              state_q, state_d;
    logic                lastIbus_q, lastIbus_d;
    logic                memRead_q, memRead_d;
    logic                memWrite_q, memWrite_d;
    logic [14:0]         memAddr_q, memAddr_d;
    logic [47:0]         memWdata_q, memWdata_d;
    logic [47:0]         ibusInput_q, ibusInput_d;
    logic [47:0]         dbusInput_q, dbusInput_d;
    logic                ibusDone_q, ibusDone_d;
    logic                dbusDone_q, dbusDone_d;
    logic                busError_q, busError_d;
    logic [TMO_BITS-1:0] tmo_q, tmo_d;

    logic                dataReq;
    logic [TMO_BITS-1:0] tmoNext;
    logic                tmoExpire;

    assign dataReq   = dbus_read | dbus_write;
    assign tmoNext   = tmo_q + TMO_ONE;
    // Expire on the cycle whose increment would reach all-ones, so the
    // strobe lasts exactly 2**TMO_BITS-1 cycles.
    assign tmoExpire = !mem_done && ((tmoNext == TMO_MAX) || (tmo_q == TMO_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dataReq && (!ibus_fetch || lastIbus_q)) begin
                    state_d = DBUS;
                end else if (ibus_fetch) begin
                    state_d = IBUS;
                end
            end
            DBUS, IBUS: begin
                if (mem_done || tmoExpire) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lastIbus_d  = lastIbus_q;
        memRead_d   = 1'b0;
        memWrite_d  = 1'b0;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        ibusInput_d = ibusInput_q;
        dbusInput_d = dbusInput_q;
        ibusDone_d  = 1'b0;
        dbusDone_d  = 1'b0;
        busError_d  = busError_q;
        tmo_d       = tmo_q;
        case (state_q)
            IDLE: begin
                if (state_d == DBUS) begin
                    lastIbus_d = 1'b0;
                    memAddr_d  = dbus_addr;
                    memWdata_d = dbus_output;
                    memWrite_d = dbus_write;
                    memRead_d  = !dbus_write;
                    tmo_d      = '0;
                end else if (state_d == IBUS) begin
                    lastIbus_d = 1'b1;
                    memAddr_d  = ibus_addr;
                    memRead_d  = 1'b1;
                    tmo_d      = '0;
                end
            end
            DBUS: begin
                if (mem_done) begin
                    dbusDone_d = 1'b1;
                    if (!memWrite_q) begin
                        dbusInput_d = mem_rdata;
                    end
                end else if (tmoExpire) begin
                    dbusDone_d  = 1'b1;
                    dbusInput_d = '0;
                    busError_d  = 1'b1;
                    tmo_d       = TMO_MAX;
                end else begin
                    memRead_d  = memRead_q;
                    memWrite_d = memWrite_q;
                    tmo_d      = tmoNext;
                end
            end
            IBUS: begin
                if (mem_done) begin
                    ibusDone_d  = 1'b1;
                    ibusInput_d = mem_rdata;
                end else if (tmoExpire) begin
                    ibusDone_d  = 1'b1;
                    ibusInput_d = '0;
                    busError_d  = 1'b1;
                    tmo_d       = TMO_MAX;
                end else begin
                    memRead_d = 1'b1;
                    tmo_d     = tmoNext;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastIbus_q  <= 1'b1;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            ibusInput_q <= '0;
            dbusInput_q <= '0;
            ibusDone_q  <= 1'b0;
            dbusDone_q  <= 1'b0;
            busError_q  <= 1'b0;
            tmo_q       <= '0;
        end else begin
            lastIbus_q  <= lastIbus_d;
            memRead_q   <= memRead_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            ibusInput_q <= ibusInput_d;
            dbusInput_q <= dbusInput_d;
            ibusDone_q  <= ibusDone_d;
            dbusDone_q  <= dbusDone_d;
            busError_q  <= busError_d;
            tmo_q       <= tmo_d;
        end
    end

    assign mem_read   = memRead_q;
    assign mem_write  = memWrite_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;
    assign ibus_input = ibusInput_q;
    assign dbus_input = dbusInput_q;
    assign ibus_done  = ibusDone_q;
    assign dbus_done  = dbusDone_q;
    assign bus_error  = busError_q;

endmodule
